// File: rtl/readout_pkg.sv
// Shared types and default sizing for the spectrogram readout sequencer.
package readout_pkg;

   localparam int N_TIME_DEF = 16;
   localparam int N_BIN_DEF  = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT,
      SHIFT
   } state_t;

endpackage

// File: rtl/readout_shift_reg.sv
// Word holding register that emits 2-bit beats MSB-first.
module readout_shift_reg
   import readout_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] load_data,
   output logic [1:0]        beat,
   output logic              first_beat,
   output logic              last_beat
);

   localparam int NB = DATA_W / 2;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   logic [DATA_W-1:0] r_data;
   logic [IW-1:0]     r_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_idx  <= '0;
      end else if (clr) begin
         r_data <= '0;
         r_idx  <= '0;
      end else if (load) begin
         r_data <= load_data;
         r_idx  <= '0;
      end else if (shift) begin
         r_data <= r_data << 2;
         r_idx  <= last_beat ? '0 : r_idx + IDX_ONE;
      end
   end

   assign beat       = r_data[DATA_W-1 -: 2];
   assign first_beat = (r_idx == '0);
   assign last_beat  = (r_idx == IDX_LAST);

endmodule

// File: rtl/readout_sequencer.sv
// Walks time/channel/bin memory order and serializes each word as 2-bit beats.
module readout_sequencer
   import readout_pkg::*;
#(
   parameter int N_TIME = N_TIME_DEF,
   parameter int N_BIN  = N_BIN_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      readout_tick,
   output logic                      mem_rd_en,
   output logic                      mem_ch,
   output logic [$clog2(N_TIME)-1:0] mem_time_addr,
   output logic [$clog2(N_BIN)-1:0]  mem_bin_addr,
   input  logic [DATA_W-1:0]         mem_rd_data,
   output logic [1:0]                serial_out,
   output logic                      sl_time,
   output logic                      sl_ch,
   output logic                      sending_data,
   output logic                      done
);

   localparam int TW = $clog2(N_TIME);
   localparam int BW = $clog2(N_BIN);
   localparam logic [TW-1:0] T_LAST = TW'(N_TIME - 1);
   localparam logic [BW-1:0] B_LAST = BW'(N_BIN - 1);
   localparam logic [TW-1:0] T_ONE  = TW'(1);
   localparam logic [BW-1:0] B_ONE  = BW'(1);

   state_t        r_state;
   logic [TW-1:0] r_time;
   logic          r_ch;
   logic [BW-1:0] r_bin;
   logic          r_done;

   logic       w_in_shift;
   logic       w_load;
   logic       w_shift;
   logic [1:0] w_beat;
   logic       w_first;
   logic       w_last;
   logic       w_final;

   assign w_in_shift = (r_state == SHIFT);
   assign w_load     = (r_state == WAIT);
   assign w_shift    = w_in_shift && readout_tick;
   assign w_final    = (r_time == T_LAST) && r_ch && (r_bin == B_LAST);

   readout_shift_reg #(
      .DATA_W(DATA_W)
   ) u_sr (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (abort),
      .load      (w_load),
      .shift     (w_shift),
      .load_data (mem_rd_data),
      .beat      (w_beat),
      .first_beat(w_first),
      .last_beat (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_time  <= '0;
         r_ch    <= 1'b0;
         r_bin   <= '0;
         r_done  <= 1'b0;
      end else if (abort) begin
         r_state <= IDLE;
         r_time  <= '0;
         r_ch    <= 1'b0;
         r_bin   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= FETCH;
                  r_time  <= '0;
                  r_ch    <= 1'b0;
                  r_bin   <= '0;
               end
            end
            FETCH: r_state <= WAIT;
            WAIT:  r_state <= SHIFT;
            SHIFT: begin
               if (readout_tick && w_last) begin
                  if (w_final) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                     r_time  <= '0;
                     r_ch    <= 1'b0;
                     r_bin   <= '0;
                  end else begin
                     r_state <= FETCH;
                     // bin wraps into channel, channel wraps into time slot
                     if (r_bin == B_LAST) begin
                        r_bin <= '0;
                        r_ch  <= ~r_ch;
                        if (r_ch) begin
                           r_time <= r_time + T_ONE;
                        end
                     end else begin
                        r_bin <= r_bin + B_ONE;
                     end
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_rd_en     = (r_state == FETCH);
   assign mem_ch        = r_ch;
   assign mem_time_addr = r_time;
   assign mem_bin_addr  = r_bin;
   assign sending_data  = w_in_shift;
   assign serial_out    = w_in_shift ? w_beat : 2'b00;
   assign sl_ch         = w_in_shift && w_first && (r_bin == '0);
   assign sl_time       = sl_ch && !r_ch;
   assign done          = r_done;

endmodule

// File: tb/tb_readout_sequencer.sv
// Randomized bench for readout_sequencer against a word-order/beat model.
module tb_readout_sequencer;

   localparam int NT    = 16;
   localparam int NB    = 8;
   localparam int DW    = 8;
   localparam int NBEAT = DW / 2;
   localparam int NW    = NT * 2 * NB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       readout_tick = 1'b0;
   logic       mem_rd_en;
   logic       mem_ch;
   logic [3:0] mem_time_addr;
   logic [2:0] mem_bin_addr;
   logic [7:0] mem_rd_data;
   logic [1:0] serial_out;
   logic       sl_time;
   logic       sl_ch;
   logic       sending_data;
   logic       done;

   logic [7:0] mem [NT][2][NB];

   int n_vec = 0;
   int n_err = 0;
   int n_done = 0;
   int cur_w = 0;

   always #5 clk = ~clk;

   readout_sequencer #(
      .N_TIME(NT),
      .N_BIN (NB),
      .DATA_W(DW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .readout_tick (readout_tick),
      .mem_rd_en    (mem_rd_en),
      .mem_ch       (mem_ch),
      .mem_time_addr(mem_time_addr),
      .mem_bin_addr (mem_bin_addr),
      .mem_rd_data  (mem_rd_data),
      .serial_out   (serial_out),
      .sl_time      (sl_time),
      .sl_ch        (sl_ch),
      .sending_data (sending_data),
      .done         (done)
   );

   always @(posedge clk)
      if (mem_rd_en)
         mem_rd_data <= mem[mem_time_addr][mem_ch][mem_bin_addr];

   always @(negedge clk)
      if (done === 1'b1)
         n_done++;

   task automatic expect_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s word=%0d: got %0h expected %0h",
                  tag, cur_w, got, exp);
      end
   endtask

   task automatic idle_quiet(input string tag);
      expect_eq({tag, "_rd"}, mem_rd_en, 0);
      expect_eq({tag, "_sd"}, sending_data, 0);
      expect_eq({tag, "_so"}, serial_out, 0);
      expect_eq({tag, "_slt"}, sl_time, 0);
      expect_eq({tag, "_slc"}, sl_ch, 0);
   endtask

   // mode: 0 normal+tick noise, 1 restart attempt at word 37,
   // 2 abort at word 100, 3 reset in WAIT, 4 reset in SHIFT
   task automatic run(input int mode);
      int t, c, b, g, nt, nc, d0;
      logic [7:0] word;
      logic [1:0] eb;
      nt = 0;
      nc = 0;
      d0 = n_done;
      cur_w = -1;
      readout_tick = 1'b1;
      @(negedge clk);
      readout_tick = 1'b0;
      idle_quiet("idle_tick");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int w = 0; w < NW; w++) begin
         cur_w = w;
         t = w / (2 * NB);
         c = (w / NB) % 2;
         b = w % NB;
         word = mem[t][c][b];
         expect_eq("fetch_rd", mem_rd_en, 1);
         expect_eq("addr", {mem_time_addr, mem_ch, mem_bin_addr},
                   {t[3:0], c[0], b[2:0]});
         expect_eq("fetch_sd", sending_data, 0);
         readout_tick = (mode == 0);
         @(negedge clk);
         readout_tick = 1'b0;
         expect_eq("wait_rd", mem_rd_en, 0);
         expect_eq("wait_sd", sending_data, 0);
         if (mode == 3 && w == 5) begin
            #1 rst_n = 1'b0;
            #1 idle_quiet("rst_wait");
            expect_eq("rst_wait_done", done, 0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            idle_quiet("after_rst_wait");
            expect_eq("rst_wait_nodone", n_done - d0, 0);
            return;
         end
         readout_tick = (mode == 0);
         @(negedge clk);
         readout_tick = 1'b0;
         for (int k = 0; k < NBEAT; k++) begin
            eb = 2'((word >> (DW - 2 - 2 * k)) & 8'd3);
            expect_eq("sd", sending_data, 1);
            expect_eq("beat", serial_out, eb);
            expect_eq("sl_time", sl_time, (k == 0 && c == 0 && b == 0));
            expect_eq("sl_ch", sl_ch, (k == 0 && b == 0));
            nt += int'(sl_time);
            nc += int'(sl_ch);
            if (mode == 4 && w == 9 && k == 2) begin
               #1 rst_n = 1'b0;
               #1 idle_quiet("rst_shift");
               @(negedge clk);
               rst_n = 1'b1;
               repeat (3) @(negedge clk);
               idle_quiet("after_rst_shift");
               expect_eq("rst_shift_nodone", n_done - d0, 0);
               return;
            end
            if (mode == 2 && w == 100 && k == 1) begin
               abort = 1'b1;
               readout_tick = 1'b1;
               @(negedge clk);
               abort = 1'b0;
               readout_tick = 1'b0;
               idle_quiet("abort");
               repeat (3) @(negedge clk);
               idle_quiet("abort_hold");
               expect_eq("abort_nodone", n_done - d0, 0);
               return;
            end
            g = 3 + $urandom_range(0, 3);
            for (int j = 0; j < g; j++) begin
               start = (mode == 1 && w == 37 && j == 0);
               @(negedge clk);
               start = 1'b0;
               expect_eq("hold", serial_out, eb);
            end
            readout_tick = 1'b1;
            @(negedge clk);
            readout_tick = 1'b0;
         end
      end
      cur_w = NW;
      expect_eq("done", done, 1);
      idle_quiet("end");
      @(negedge clk);
      expect_eq("done_pulse", done, 0);
      expect_eq("done_count", n_done - d0, 1);
      expect_eq("sl_time_count", nt, NT);
      expect_eq("sl_ch_count", nc, 2 * NT);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      idle_quiet("reset");
      expect_eq("reset_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int t = 0; t < NT; t++)
         for (int c = 0; c < 2; c++)
            for (int b = 0; b < NB; b++)
               mem[t][c][b] = 8'($urandom);
      mem[0][0][0] = 8'hB4;
      run(0);
      run(2);
      for (int t = 0; t < NT; t++)
         for (int c = 0; c < 2; c++)
            for (int b = 0; b < NB; b++)
               mem[t][c][b] = {4'(t), 1'(c), 3'(b)};
      run(1);
      run(3);
      run(4);
      run(0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
